// File: rtl/mux_switch_ctrl.sv
// mux_switch_ctrl: sequences the mux_2x1 select through blank -> switch -> settle,
// holding downstream consumers for the whole sequence.
module mux_switch_ctrl #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic        RESET_SEL = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_sel_i,
    output logic                 req_ready_o,
    input  logic [LEN_WIDTH-1:0] blank_len_i,
    input  logic [LEN_WIDTH-1:0] settle_len_i,
    output logic                 sel_o,
    output logic                 hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] switch_count_o
);
    typedef enum logic [1:0] {IDLE, BLANK, SWITCH, SETTLE} state_t;
    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, settle_q, settle_d;
    logic                 target_q, target_d, sel_d, done_d;
    logic [CNT_WIDTH-1:0] count_d;
    assign req_ready_o = state_q == IDLE;
    assign busy_o      = ~req_ready_o;
    assign hold_o      = busy_o;
    // Phase counters load the full length and finish on 1, so all-ones lengths fit LEN_WIDTH.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        target_d = target_q;
        sel_d    = sel_o;
        done_d   = 1'b0;
        count_d  = switch_count_o;
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_sel_i != sel_o) begin
                    state_d  = BLANK;
                    target_d = req_sel_i;
                    cnt_d    = blank_len_i == '0 ? LEN_WIDTH'(1) : blank_len_i;
                    settle_d = settle_len_i;
                end
            end
            BLANK: begin
                if (cnt_q == LEN_WIDTH'(1)) begin
                    sel_d   = target_q;
                    state_d = SWITCH;
                end else begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                end
            end
            SWITCH: begin
                if (settle_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    count_d = switch_count_o + CNT_WIDTH'(1);
                end else begin
                    state_d = SETTLE;
                    cnt_d   = settle_q;
                end
            end
            SETTLE: begin
                if (cnt_q == LEN_WIDTH'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    count_d = switch_count_o + CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            settle_q       <= '0;
            target_q       <= RESET_SEL;
            sel_o          <= RESET_SEL;
            done_o         <= 1'b0;
            switch_count_o <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            settle_q       <= settle_d;
            target_q       <= target_d;
            sel_o          <= sel_d;
            done_o         <= done_d;
            switch_count_o <= count_d;
        end
    end
endmodule
